// File: rtl/arp_tx_frame_gen.sv
// Serializes one Ethernet+ARP frame per arbiter request as a byte-wide AXI-Stream.
// Fields are latched at the start edge; the frame is optionally zero-padded to 60 bytes.
module arp_tx_frame_gen #(
  parameter int PAD_TO_MIN = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        arp_tx_start,
  input  logic        arp_oper,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [47:0] target_mac,
  input  logic [31:0] target_ip,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        arp_data_tx_done
);

  localparam logic [5:0] LAST = (PAD_TO_MIN != 0) ? 6'd59 : 6'd41;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        start_d;
  logic        start_hit;
  logic        cap_oper;
  logic [47:0] cap_lmac;
  logic [31:0] cap_lip;
  logic [47:0] cap_tmac;
  logic [31:0] cap_tip;

  function automatic logic [7:0] pick(input logic [47:0] f, input int n);
    return 8'(f >> (8 * n));
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic [5:0]  idx,
    input logic        oper,
    input logic [47:0] lmac,
    input logic [31:0] lip,
    input logic [47:0] tmac,
    input logic [31:0] tip
  );
    logic [47:0] dst;
    logic [47:0] tha;
    logic [7:0]  b;
    int          i;
    i   = int'(idx);
    dst = oper ? 48'hFFFF_FFFF_FFFF : tmac;
    tha = oper ? 48'h0 : tmac;
    b   = 8'h00;
    if (i < 6)        b = pick(dst, 5 - i);
    else if (i < 12)  b = pick(lmac, 11 - i);
    else if (i == 12) b = 8'h08;
    else if (i == 13) b = 8'h06;
    else if (i == 14) b = 8'h00;
    else if (i == 15) b = 8'h01;
    else if (i == 16) b = 8'h08;
    else if (i == 17) b = 8'h00;
    else if (i == 18) b = 8'h06;
    else if (i == 19) b = 8'h04;
    else if (i == 20) b = 8'h00;
    else if (i == 21) b = oper ? 8'h01 : 8'h02;
    else if (i < 28)  b = pick(lmac, 27 - i);
    else if (i < 32)  b = pick({16'h0, lip}, 31 - i);
    else if (i < 38)  b = pick(tha, 37 - i);
    else if (i < 42)  b = pick({16'h0, tip}, 41 - i);
    return b;
  endfunction

  // A level held high or an edge while busy never starts a frame.
  assign start_hit = arp_tx_start && !start_d && (state == IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      start_d <= 1'b0;
      cnt     <= '0;
    end else begin
      start_d <= arp_tx_start;
      if (start_hit)
        cnt <= '0;
      else if (state == SEND && m_axis_tready && cnt != LAST)
        cnt <= cnt + 6'd1;
    end
  end

  // Field capture is data only; frame content comes solely from these copies.
  always_ff @(posedge aclk) begin
    if (start_hit) begin
      cap_oper <= arp_oper;
      cap_lmac <= local_mac;
      cap_lip  <= local_ip;
      cap_tmac <= target_mac;
      cap_tip  <= target_ip;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_hit) state_nxt = SEND;
      SEND:    if (m_axis_tready && cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid    = 1'b0;
    m_axis_tlast     = 1'b0;
    m_axis_tdata     = 8'h00;
    arp_data_tx_done = 1'b0;
    case (state)
      SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (cnt == LAST);
        m_axis_tdata  = frame_byte(cnt, cap_oper, cap_lmac, cap_lip, cap_tmac, cap_tip);
      end
      DONE:    arp_data_tx_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arp_tx_frame_gen.sv
// Randomized bench for arp_tx_frame_gen: a padded and an unpadded instance run side by side
// against a frame model built from field concatenation.
module tb_arp_tx_frame_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        arp_tx_start = 1'b0;
  logic        arp_oper = 1'b1;
  logic [47:0] local_mac = '0;
  logic [31:0] local_ip = '0;
  logic [47:0] target_mac = '0;
  logic [31:0] target_ip = '0;
  logic        m_axis_tready = 1'b1;
  logic        stall_mode = 1'b0;

  logic [7:0]  tdata [2];
  logic        tvalid [2];
  logic        tlast [2];
  logic        done [2];

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  arp_tx_frame_gen #(.PAD_TO_MIN(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .arp_tx_start(arp_tx_start), .arp_oper(arp_oper),
    .local_mac(local_mac), .local_ip(local_ip), .target_mac(target_mac), .target_ip(target_ip),
    .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tlast(tlast[0]),
    .m_axis_tready(m_axis_tready), .arp_data_tx_done(done[0]));

  arp_tx_frame_gen #(.PAD_TO_MIN(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .arp_tx_start(arp_tx_start), .arp_oper(arp_oper),
    .local_mac(local_mac), .local_ip(local_ip), .target_mac(target_mac), .target_ip(target_ip),
    .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tlast(tlast[1]),
    .m_axis_tready(m_axis_tready), .arp_data_tx_done(done[1]));

  always @(posedge aclk) begin
    #1;
    m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor sampled on the falling edge: a valid&&ready seen here is the next rising-edge handshake.
  logic [7:0] q [2][$];
  int         cyc = 0;
  int         stall_err [2] = '{0, 0};
  int         ovl_err [2]   = '{0, 0};
  int         done_cnt [2]  = '{0, 0};
  int         last_cnt [2]  = '{0, 0};
  int         last_idx [2]  = '{0, 0};
  int         hs_cyc [2]    = '{0, 0};
  int         done_cyc [2]  = '{0, 0};
  logic       prev_stall [2] = '{1'b0, 1'b0};
  logic [7:0] prev_data [2]  = '{8'h0, 8'h0};
  logic       prev_last [2]  = '{1'b0, 1'b0};

  always @(negedge aclk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (prev_stall[k] && (!tvalid[k] || tdata[k] !== prev_data[k] || tlast[k] !== prev_last[k]))
        stall_err[k] <= stall_err[k] + 1;
      if (tvalid[k] && done[k]) ovl_err[k] <= ovl_err[k] + 1;
      if (done[k]) begin
        done_cnt[k] <= done_cnt[k] + 1;
        done_cyc[k] <= cyc;
      end
      if (tvalid[k] && m_axis_tready) begin
        if (tlast[k]) begin
          last_cnt[k] <= last_cnt[k] + 1;
          last_idx[k] <= q[k].size();
        end
        q[k].push_back(tdata[k]);
        hs_cyc[k] <= cyc;
      end
      prev_stall[k] <= tvalid[k] && !m_axis_tready;
      prev_data[k]  <= tdata[k];
      prev_last[k]  <= tlast[k];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  logic [7:0] exp_q [2][$];

  task automatic build_exp(input int k);
    logic [335:0] f;
    logic [47:0]  dst;
    logic [47:0]  tha;
    dst = arp_oper ? 48'hFFFF_FFFF_FFFF : target_mac;
    tha = arp_oper ? 48'h0 : target_mac;
    f = {dst, local_mac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
         (arp_oper ? 16'h0001 : 16'h0002), local_mac, local_ip, tha, target_ip};
    exp_q[k].delete();
    for (int i = 0; i < 42; i++) exp_q[k].push_back(8'(f >> (8 * (41 - i))));
    if (k == 1) for (int i = 42; i < 60; i++) exp_q[k].push_back(8'h00);
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic randomize_fields();
    arp_oper   = 1'($urandom_range(0, 1));
    local_mac  = rnd48();
    local_ip   = $urandom;
    target_mac = rnd48();
    target_ip  = $urandom;
  endtask

  task automatic run_frame(input bit stall, input bit busy_edge);
    int b_sz [2];
    int b_st [2];
    int b_ov [2];
    int b_dn [2];
    int b_lc [2];
    int nbad;
    bit ok;
    stall_mode = stall;
    for (int k = 0; k < 2; k++) begin
      b_sz[k] = q[k].size();
      b_st[k] = stall_err[k];
      b_ov[k] = ovl_err[k];
      b_dn[k] = done_cnt[k];
      b_lc[k] = last_cnt[k];
      build_exp(k);
    end
    @(posedge aclk); #1;
    arp_tx_start = 1'b1;
    check("idle_vld", {62'h0, tvalid[1], tvalid[0]}, 64'h0);
    @(posedge aclk); #1;
    check("first_vld", {62'h0, tvalid[1], tvalid[0]}, 64'h3);
    check("first_byte", {56'h0, tdata[1]}, {56'h0, exp_q[1][0]});
    randomize_fields();
    if (busy_edge) begin
      repeat (4) @(posedge aclk);
      #1 arp_tx_start = 1'b0;
      @(posedge aclk);
      #1 arp_tx_start = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge aclk);
      if (done_cnt[0] > b_dn[0] && done_cnt[1] > b_dn[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_end", {63'h0, ok}, 64'h1);
    repeat (20) @(posedge aclk);
    #1 arp_tx_start = 1'b0;
    repeat (2) @(posedge aclk);
    for (int k = 0; k < 2; k++) begin
      nbad = 0;
      for (int i = 0; i < exp_q[k].size(); i++)
        if (b_sz[k] + i >= q[k].size() || q[k][b_sz[k] + i] !== exp_q[k][i]) nbad++;
      check($sformatf("len%0d", k), 64'(q[k].size() - b_sz[k]), 64'(exp_q[k].size()));
      check($sformatf("bytes%0d", k), 64'(nbad), 64'h0);
      check($sformatf("tlast_cnt%0d", k), 64'(last_cnt[k] - b_lc[k]), 64'h1);
      check($sformatf("tlast_pos%0d", k), 64'(last_idx[k] - b_sz[k]), 64'(exp_q[k].size() - 1));
      check($sformatf("done_cnt%0d", k), 64'(done_cnt[k] - b_dn[k]), 64'h1);
      check($sformatf("done_lat%0d", k), 64'(done_cyc[k] - hs_cyc[k]), 64'h1);
      check($sformatf("stall%0d", k), 64'(stall_err[k] - b_st[k]), 64'h0);
      check($sformatf("overlap%0d", k), 64'(ovl_err[k] - b_ov[k]), 64'h0);
    end
  endtask

  task automatic reset_mid_frame();
    int b_sz;
    int b_dn;
    int b_lc;
    bit ok;
    stall_mode = 1'b0;
    b_sz = q[1].size();
    b_dn = done_cnt[0] + done_cnt[1];
    b_lc = last_cnt[0] + last_cnt[1];
    @(posedge aclk); #1;
    arp_tx_start = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (q[1].size() - b_sz >= 25) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach25", {63'h0, ok}, 64'h1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_vld", {62'h0, tvalid[1], tvalid[0]}, 64'h0);
    check("rst_last", {62'h0, tlast[1], tlast[0]}, 64'h0);
    arp_tx_start = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    check("rst_nodone", 64'(done_cnt[0] + done_cnt[1] - b_dn), 64'h0);
    check("rst_nolast", 64'(last_cnt[0] + last_cnt[1] - b_lc), 64'h0);
    check("rst_idle", {62'h0, tvalid[1], tvalid[0]}, 64'h0);
  endtask

  initial begin
    int s;
    #12;
    check("reset_out", {52'h0, tdata[1], tvalid[1], tlast[1], done[1], tvalid[0]}, 64'h0);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    arp_oper   = 1'b1;
    local_mac  = 48'h02_00_00_00_00_01;
    local_ip   = 32'hC0A8_010A;
    target_ip  = 32'hC0A8_0101;
    target_mac = rnd48();
    s = q[1].size();
    run_frame(1'b0, 1'b0);
    check("req_dst0", {56'h0, q[1][s]}, 64'hFF);
    check("req_oper", {56'h0, q[1][s + 21]}, 64'h01);
    check("req_tpa3", {56'h0, q[1][s + 41]}, 64'h01);
    check("req_pad", {56'h0, q[1][s + 59]}, 64'h00);

    arp_oper   = 1'b0;
    target_mac = 48'hAA_BB_CC_DD_EE_FF;
    s = q[1].size();
    run_frame(1'b0, 1'b0);
    check("rep_dst0", {56'h0, q[1][s]}, 64'hAA);
    check("rep_tha5", {56'h0, q[1][s + 37]}, 64'hFF);
    check("rep_oper", {56'h0, q[1][s + 21]}, 64'h02);

    for (int n = 0; n < 6; n++) begin
      randomize_fields();
      run_frame(1'b1, n[0]);
    end

    randomize_fields();
    reset_mid_frame();
    randomize_fields();
    run_frame(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
